sap_ctrl_seq: RTL and testbench

- Control sequencer for the 8-bit bus computer.
- Steps through fetch/execute T-states and decodes the opcode from the instruction register.
- Drives the load and drive strobes for the MAR/RAM block, PC, IR, A/B registers, ALU and output register.
- Sits beside the shared 8-bit bus; its outputs are the bus-wide control word.

---
 rtl/sap_ctrl_seq.sv | 166 ++++++++++++++++
 tb/tb_sap_ctrl_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_ctrl_seq.sv
// Control sequencer for the 8-bit bus computer: T-state counter, opcode decode, control word.
// Optional SAP_CTRL_STEP_EN adds a single-step input that gates advance and load strobes.
module sap_ctrl_seq #(
    parameter int WIDTH     = 8,
    parameter bit EARLY_END = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr,
    input  logic             flag_c,
    input  logic             flag_z,
`ifdef SAP_CTRL_STEP_EN
    input  logic             step,
`endif
    output logic [2:0]       tstate,
    output logic             hlt,
    output logic             mi,
    output logic             ri,
    output logic             ro,
    output logic             ii,
    output logic             io,
    output logic             ai,
    output logic             ao,
    output logic             eo,
    output logic             su,
    output logic             bi,
    output logic             oi,
    output logic             fi,
    output logic             ce,
    output logic             co,
    output logic             j
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    tstate_t    state, state_nxt;
    logic       halted, halted_nxt;
    logic       adv;
    logic       last;
    logic [3:0] opcode;
    logic       mi_u, ri_u, ii_u, ai_u, bi_u, oi_u, fi_u, ce_u, j_u;
    logic       unused_operand;

    assign opcode         = instr[WIDTH-1:WIDTH-4];
    assign unused_operand = ^instr[WIDTH-5:0];

`ifdef SAP_CTRL_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= T0;
            halted <= 1'b0;
        end else if (adv) begin
            state  <= state_nxt;
            halted <= halted_nxt;
        end
    end

    always_comb begin
        hlt  = 1'b0;
        ro   = 1'b0;
        io   = 1'b0;
        ao   = 1'b0;
        eo   = 1'b0;
        su   = 1'b0;
        co   = 1'b0;
        mi_u = 1'b0;
        ri_u = 1'b0;
        ii_u = 1'b0;
        ai_u = 1'b0;
        bi_u = 1'b0;
        oi_u = 1'b0;
        fi_u = 1'b0;
        ce_u = 1'b0;
        j_u  = 1'b0;
        last = 1'b0;
        if (halted) begin
            hlt = 1'b1;
        end else begin
            unique case (state)
                T0: begin co = 1'b1; mi_u = 1'b1; end
                T1: begin ro = 1'b1; ii_u = 1'b1; ce_u = 1'b1; end
                T2: begin
                    last = 1'b1;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            io = 1'b1; mi_u = 1'b1; last = 1'b0;
                        end
                        OP_LDI: begin io = 1'b1; ai_u = 1'b1; end
                        OP_JMP: begin io = 1'b1; j_u = 1'b1; end
                        OP_JC:  if (flag_c) begin io = 1'b1; j_u = 1'b1; end
                        OP_JZ:  if (flag_z) begin io = 1'b1; j_u = 1'b1; end
                        OP_OUT: begin ao = 1'b1; oi_u = 1'b1; end
                        OP_HLT: hlt = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin ro = 1'b1; ai_u = 1'b1; last = 1'b1; end
                        OP_ADD, OP_SUB: begin ro = 1'b1; bi_u = 1'b1; end
                        OP_STA: begin ao = 1'b1; ri_u = 1'b1; last = 1'b1; end
                        default: ;
                    endcase
                end
                T4: begin
                    last = 1'b1;
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        eo = 1'b1; ai_u = 1'b1; fi_u = 1'b1;
                        su = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    // HLT holds tstate at T2 rather than taking its early-end wrap to T0.
    always_comb begin
        state_nxt  = state;
        halted_nxt = halted;
        if (!halted) begin
            if (state == T2 && opcode == OP_HLT) begin
                halted_nxt = 1'b1;
            end else if (state == T4 || (EARLY_END && last)) begin
                state_nxt = T0;
            end else begin
                state_nxt = tstate_t'(state + 3'd1);
            end
        end
    end

    assign tstate = state;
    assign mi     = mi_u & adv;
    assign ri     = ri_u & adv;
    assign ii     = ii_u & adv;
    assign ai     = ai_u & adv;
    assign bi     = bi_u & adv;
    assign oi     = oi_u & adv;
    assign fi     = fi_u & adv;
    assign ce     = ce_u & adv;
    assign j      = j_u & adv;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Self-checking bench for sap_ctrl_seq: vector table, hand sequences, random run vs. reference model.
// Two instances: EARLY_END=1 (index 0) and EARLY_END=0 (index 1).
module tb_sap_ctrl_seq;

    localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
    localparam logic [15:0] II  = 16'h0800, IO = 16'h0400, AI = 16'h0200, AO = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
    localparam logic [15:0] FI  = 16'h0008, CE = 16'h0004, CO = 16'h0002, J  = 16'h0001;
    localparam logic [15:0] LOADS = MI | RI | II | AI | BI | OI | FI | CE | J;
    localparam logic [15:0] DRIVES = CO | RO | IO | AO | EO;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  iv [2];
    logic        flag_c = 1'b0, flag_z = 1'b0;
    logic        step = 1'b1;
    logic [2:0]  ts [2];
    logic [15:0] w0, w1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  instr;
        logic        c, z;
        logic [2:0]  t;
        logic [15:0] w;
    } vec_t;
    vec_t tbl[$];

    logic [15:0] uc [16][5];
    int          lastt [16];
    int          mt [2];
    bit          mh [2];

    always #5 clk = ~clk;

    sap_ctrl_seq #(.WIDTH(8), .EARLY_END(1'b1)) dut0 (
        .clk(clk), .rst(rst), .instr(iv[0]), .flag_c(flag_c), .flag_z(flag_z),
`ifdef SAP_CTRL_STEP_EN
        .step(step),
`endif
        .tstate(ts[0]), .hlt(w0[15]), .mi(w0[14]), .ri(w0[13]), .ro(w0[12]), .ii(w0[11]),
        .io(w0[10]), .ai(w0[9]), .ao(w0[8]), .eo(w0[7]), .su(w0[6]), .bi(w0[5]),
        .oi(w0[4]), .fi(w0[3]), .ce(w0[2]), .co(w0[1]), .j(w0[0])
    );

    sap_ctrl_seq #(.WIDTH(8), .EARLY_END(1'b0)) dut1 (
        .clk(clk), .rst(rst), .instr(iv[1]), .flag_c(flag_c), .flag_z(flag_z),
`ifdef SAP_CTRL_STEP_EN
        .step(step),
`endif
        .tstate(ts[1]), .hlt(w1[15]), .mi(w1[14]), .ri(w1[13]), .ro(w1[12]), .ii(w1[11]),
        .io(w1[10]), .ai(w1[9]), .ao(w1[8]), .eo(w1[7]), .su(w1[6]), .bi(w1[5]),
        .oi(w1[4]), .fi(w1[3]), .ce(w1[2]), .co(w1[1]), .j(w1[0])
    );

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_async_t", {13'd0, ts[0]}, 16'd0);
        chk("rst_async_w", w0, CO | MI);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_w", w0, CO | MI);
        chk("rst_hold_w1", w1, CO | MI);
        rst = 1'b0;
        #1;
        chk("rst_rel_t", {13'd0, ts[0]}, 16'd0);
        mt[0] = 0; mt[1] = 0; mh[0] = 1'b0; mh[1] = 1'b0;
    endtask

    // Microcode-style reference: per-opcode step words, instruction lengths from the opcode rules.
    function automatic void build_model();
        for (int op = 0; op < 16; op++) begin
            for (int t = 0; t < 5; t++) uc[op][t] = '0;
            uc[op][0] = CO | MI;
            uc[op][1] = RO | II | CE;
            lastt[op] = 2;
        end
        uc[1][2] = IO | MI;  uc[1][3] = RO | AI;  lastt[1] = 3;
        uc[2][2] = IO | MI;  uc[2][3] = RO | BI;  uc[2][4] = EO | AI | FI;      lastt[2] = 4;
        uc[3][2] = IO | MI;  uc[3][3] = RO | BI;  uc[3][4] = EO | AI | FI | SU; lastt[3] = 4;
        uc[4][2] = IO | MI;  uc[4][3] = AO | RI;  lastt[4] = 3;
        uc[5][2] = IO | AI;
        uc[6][2] = IO | J;
        uc[7][2] = IO | J;
        uc[8][2] = IO | J;
        uc[14][2] = AO | OI;
        uc[15][2] = HLT;
    endfunction

    function automatic logic [15:0] model_word(int d);
        int op = int'(iv[d][7:4]);
        logic [15:0] w;
        if (mh[d]) return HLT;
        w = uc[op][mt[d]];
        if (mt[d] == 2 && op == 7 && !flag_c) w = '0;
        if (mt[d] == 2 && op == 8 && !flag_z) w = '0;
        if (!step) w = w & ~LOADS;
        return w;
    endfunction

    function automatic void model_step(int d);
        int op = int'(iv[d][7:4]);
        int len_last = (d == 0) ? lastt[op] : 4;
        if (!step || mh[d]) return;
        if (mt[d] == 2 && op == 15) begin
            mh[d] = 1'b1;
            return;
        end
        mt[d] = (mt[d] == len_last) ? 0 : mt[d] + 1;
    endfunction

    function automatic void add_instr(logic [7:0] ins, logic c, logic z, int n,
                                      logic [15:0] e2, logic [15:0] e3, logic [15:0] e4);
        logic [15:0] ex [5];
        ex[0] = CO | MI; ex[1] = RO | II | CE; ex[2] = e2; ex[3] = e3; ex[4] = e4;
        for (int t = 0; t < n; t++) tbl.push_back('{ins, c, z, 3'(t), ex[t]});
    endfunction

    initial begin
        int hcnt;
        iv[0] = 8'h00; iv[1] = 8'h00;
        build_model();

        add_instr(8'h2A, 0, 0, 5, IO | MI, RO | BI, EO | AI | FI);
        add_instr(8'h3A, 0, 0, 5, IO | MI, RO | BI, EO | AI | FI | SU);
        add_instr(8'h7F, 0, 1, 3, '0, '0, '0);
        add_instr(8'h7F, 1, 0, 3, IO | J, '0, '0);
        add_instr(8'h8F, 1, 0, 3, '0, '0, '0);
        add_instr(8'h8F, 0, 1, 3, IO | J, '0, '0);
        add_instr(8'h1E, 0, 0, 4, IO | MI, RO | AI, '0);
        add_instr(8'h4E, 0, 0, 4, IO | MI, AO | RI, '0);
        add_instr(8'h53, 0, 0, 3, IO | AI, '0, '0);
        add_instr(8'hE0, 0, 0, 3, AO | OI, '0, '0);
        add_instr(8'h00, 0, 0, 3, '0, '0, '0);
        add_instr(8'hB0, 1, 1, 3, '0, '0, '0);
        add_instr(8'h00, 0, 0, 1, '0, '0, '0);

        // Table run on the early-end instance
        @(posedge clk); #1;
        do_reset();
        foreach (tbl[k]) begin
            iv[0] = tbl[k].instr; flag_c = tbl[k].c; flag_z = tbl[k].z;
            #1;
            chk($sformatf("tbl%0d_t", k), {13'd0, ts[0]}, {13'd0, tbl[k].t});
            chk($sformatf("tbl%0d_w", k), w0, tbl[k].w);
            tick();
        end

        // Full-length instance: empty steps are all-zero and every opcode takes 5 cycles
        do_reset();
        iv[1] = 8'h53;
        for (int t = 0; t < 6; t++) begin
            #1;
            chk($sformatf("ee0_t%0d", t), {13'd0, ts[1]}, 16'(t % 5));
            chk($sformatf("ee0_w%0d", t), w1,
                (t % 5 == 0) ? (CO | MI) : (t == 1) ? (RO | II | CE) : (t == 2) ? (IO | AI) : 16'h0);
            tick();
        end

        // Halt is sticky and frozen at T2 until an asynchronous reset
        do_reset();
        iv[0] = 8'hF0;
        tick(); tick();
        #1;
        chk("hlt_t2_w", w0, HLT);
        tick();
        for (int n = 0; n < 20; n++) begin
            iv[0] = 8'($urandom);
            flag_c = 1'($urandom); flag_z = 1'($urandom);
            #1;
            chk("hlt_hold_t", {13'd0, ts[0]}, 16'd2);
            chk("hlt_hold_w", w0, HLT);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("hlt_rst_t", {13'd0, ts[0]}, 16'd0);
        chk("hlt_rst_w", w0, CO | MI);
        rst = 1'b0;
        tick();

`ifdef SAP_CTRL_STEP_EN
        // Single-step: loads gated while waiting, drives remain visible
        do_reset();
        iv[0] = 8'h2A;
        tick();
        step = 1'b0;
        for (int n = 0; n < 10; n++) begin
            #1;
            chk("step_wait_t", {13'd0, ts[0]}, 16'd1);
            chk("step_wait_w", w0, RO);
            tick();
        end
        step = 1'b1;
        #1;
        chk("step_go_w", w0, RO | II | CE);
        tick();
        chk("step_go_t", {13'd0, ts[0]}, 16'd2);
`endif

        // Random run against the reference model, with bus-ownership check
        do_reset();
        hcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < 2; d++)
                if (mt[d] == 0 && !mh[d]) iv[d] = 8'($urandom);
            flag_c = 1'($urandom);
            flag_z = 1'($urandom);
`ifdef SAP_CTRL_STEP_EN
            step = ($urandom_range(0, 3) != 0);
`endif
            #1;
            chk("rnd_t0", {13'd0, ts[0]}, 16'(mt[0]));
            chk("rnd_w0", w0, model_word(0));
            chk("rnd_t1", {13'd0, ts[1]}, 16'(mt[1]));
            chk("rnd_w1", w1, model_word(1));
            chk("rnd_bus0", 16'($countones(w0 & DRIVES) > 1), 16'd0);
            chk("rnd_bus1", 16'($countones(w1 & DRIVES) > 1), 16'd0);
            model_step(0);
            model_step(1);
            tick();
            hcnt = (mh[0] || mh[1]) ? hcnt + 1 : 0;
            if (hcnt > 4 || $urandom_range(0, 63) == 0) begin
                rst = 1'b1;
                #1;
                chk("rnd_rst_t0", {13'd0, ts[0]}, 16'd0);
                chk("rnd_rst_w1", w1, CO | MI);
                rst = 1'b0;
                mt[0] = 0; mt[1] = 0; mh[0] = 1'b0; mh[1] = 1'b0;
                hcnt = 0;
            end
        end
        step = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
